fpu_div_issue: RTL and testbench

Operand issue and result-collection stage that sits directly in front of the `div` Newton-Raphson divider.
- Accepts (A, B, tag) operand pairs on a valid/ready interface and buffers them in a small FIFO.
- Drives the divider's A/B/en inputs one pair per cycle.
- Captures the divider's registered result, together with the tag and zero-division flag, into a 2-entry output buffer with valid/ready backpressure.
- Without this stage, results are lost: `div` clears its result register whenever en=0.

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fpu_sync_fifo.sv | 64 ++++++
 rtl/fpu_div_issue.sv | 118 +++++++++++
 tb/tb_fpu_div_issue.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants, result record and sizing helper
// for the divider issue/collect stage.
package fpu_pkg;

  localparam int FP32_W = 32;
  localparam logic [7:0] EXP_ZERO = 8'h00;

  // The tag travels beside this record because its width is a module parameter.
  typedef struct packed {
    logic              dz;
    logic [FP32_W-1:0] result;
  } div_res_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// fpu_sync_fifo: power-of-two synchronous FIFO, registered storage,
// pointers and count reset, storage left unreset.
module fpu_sync_fifo
  import fpu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic [clog2(DEPTH):0] count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count_q == CW'(DEPTH)));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && count_q == '0));

endmodule

// File: rtl/fpu_div_issue.sv
// fpu_div_issue: feeds the divider one operand pair per cycle and
// catches its one-cycle result before the divider clears it.
module fpu_div_issue
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_a,
  input  logic [31:0]           in_b,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  div_en,
  output logic [31:0]           div_a,
  output logic [31:0]           div_b,
  input  logic [31:0]           div_result,
  input  logic                  div_zero_division,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_result,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_dz,
  output logic [clog2(DEPTH):0] fifo_count
);

  localparam int CW    = clog2(DEPTH) + 1;
  localparam int IN_W  = 2 * FP32_W + TAG_W;
  localparam int OUT_W = $bits(div_res_t) + TAG_W;

  logic [IN_W-1:0]  in_wdata, in_rdata;
  logic [OUT_W-1:0] out_wdata, out_rdata;
  logic [1:0]       out_count;
  logic [2:0]       credit;
  logic             in_push, issue, out_pop;
  logic [TAG_W-1:0] head_tag, out_tag_raw;
  div_res_t         cap_rec, out_rec;

  logic             inflight_q, inflight_d;
  logic [TAG_W-1:0] inflight_tag_q, inflight_tag_d;
  logic             inflight_dz_q, inflight_dz_d;

  assign in_ready = fifo_count < CW'(DEPTH);
  assign in_push  = in_valid && in_ready;
  assign in_wdata = {in_tag, in_a, in_b};

  fpu_sync_fifo #(
    .WIDTH (IN_W),
    .DEPTH (DEPTH)
  ) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_push),
    .wdata (in_wdata),
    .pop   (issue),
    .rdata (in_rdata),
    .count (fifo_count)
  );

  assign {head_tag, div_a, div_b} = in_rdata;

  // Credit counts buffered plus in-flight results; a slot freed this
  // cycle by the consumer may be reused by this cycle's issue.
  assign out_valid = out_count != 2'd0;
  assign out_pop   = out_valid && out_ready;
  assign credit    = {1'b0, out_count} + {2'b0, inflight_q}
                   - {2'b0, out_pop};
  assign issue     = (fifo_count != '0) && (credit < 3'd2);
  assign div_en    = issue;

  // dz must be taken now: div_b moves to the next head after the pop.
  always_comb begin
    inflight_d     = issue;
    inflight_tag_d = inflight_tag_q;
    inflight_dz_d  = inflight_dz_q;
    if (issue) begin
      inflight_tag_d = head_tag;
      inflight_dz_d  = div_zero_division;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q     <= 1'b0;
      inflight_tag_q <= '0;
      inflight_dz_q  <= 1'b0;
    end else begin
      inflight_q     <= inflight_d;
      inflight_tag_q <= inflight_tag_d;
      inflight_dz_q  <= inflight_dz_d;
    end
  end

  assign cap_rec   = '{dz: inflight_dz_q, result: div_result};
  assign out_wdata = {inflight_tag_q, cap_rec};

  fpu_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (2)
  ) u_out_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .wdata (out_wdata),
    .pop   (out_pop),
    .rdata (out_rdata),
    .count (out_count)
  );

  assign {out_tag_raw, out_rec} = out_rdata;

  assign out_result = out_valid ? out_rec.result : '0;
  assign out_tag    = out_valid ? out_tag_raw : '0;
  assign out_dz     = out_valid && out_rec.dz;

endmodule

// File: tb/tb_fpu_div_issue.sv
// tb_fpu_div_issue: randomized bench with a stand-in divider and an
// ordered queue model of accepted operations.
`timescale 1ns/1ps
module tb_fpu_div_issue;
  import fpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             dz;
    logic [31:0]      res;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             div_en;
  logic [31:0]      div_a, div_b, div_result;
  logic             div_zero_division;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_dz;
  logic [2:0]       fifo_count;

  int checks = 0;
  int failures = 0;
  rec_t exp_q[$];
  rec_t got_q[$];
  int   got_cyc[$];
  int   cyc = 0;
  int   issued = 0;
  int   delivered = 0;
  int   max_out = 0;
  int   rdy_bad = 0;
  bit   rnd_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_div_issue #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_a              (in_a),
    .in_b              (in_b),
    .in_tag            (in_tag),
    .div_en            (div_en),
    .div_a             (div_a),
    .div_b             (div_b),
    .div_result        (div_result),
    .div_zero_division (div_zero_division),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_result        (out_result),
    .out_tag           (out_tag),
    .out_dz            (out_dz),
    .fifo_count        (fifo_count)
  );

  // Truncating single-precision divide for normal operands; zero
  // exponent on either side yields +0, as the real divider does for B.
  function automatic logic [31:0] fdiv(input logic [31:0] a,
                                       input logic [31:0] b);
    logic [47:0] q;
    logic [22:0] m;
    int          e;
    if (b[30:23] == EXP_ZERO || a[30:23] == EXP_ZERO) return 32'h0;
    q = {1'b1, a[22:0], 24'h0} / {24'h0, 1'b1, b[22:0]};
    e = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q[24]) m = q[23:1];
    else begin
      m = q[22:0];
      e = e - 1;
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  // Stand-in divider: registered quotient, cleared whenever en is low.
  logic [31:0] dv_q = '0;
  always @(posedge clk) dv_q <= div_en ? fdiv(div_a, div_b) : 32'h0;
  assign div_result        = dv_q;
  assign div_zero_division = (div_b[30:23] == EXP_ZERO);

  function automatic logic [31:0] rand_fp(input bit allow_zero);
    logic [7:0] e;
    e = 8'($urandom_range(100, 150));
    if (allow_zero && $urandom_range(0, 7) == 0) e = 8'h00;
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      issued    <= 0;
      delivered <= 0;
    end else begin
      if (in_valid && in_ready)
        exp_q.push_back(rec_t'{tag: in_tag,
                               dz: (in_b[30:23] == EXP_ZERO),
                               res: fdiv(in_a, in_b)});
      if (out_valid && out_ready) begin
        got_q.push_back(rec_t'{tag: out_tag, dz: out_dz, res: out_result});
        got_cyc.push_back(cyc);
      end
      if (in_ready !== (fifo_count < 3'(DEPTH))) rdy_bad <= rdy_bad + 1;
      issued    <= issued + int'(div_en);
      delivered <= delivered + int'(out_valid && out_ready);
      if (issued + int'(div_en) - delivered
          - int'(out_valid && out_ready) > max_out)
        max_out <= issued + int'(div_en) - delivered
                   - int'(out_valid && out_ready);
    end
  end

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t);
    int n;
    n = 0;
    in_a = a;
    in_b = b;
    in_tag = t;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout tag=%0d", t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input int lim);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (got_q.size() < n && k < lim);
    #1;
    checks++;
    if (got_q.size() < n) begin
      failures++;
      $display("FAIL wait_got got=%0d need=%0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (div_en !== 1'b0) begin failures++; $display("FAIL rst_hold_div_en got=%b exp=0", div_en); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_hold_out_valid got=%b exp=0", out_valid); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (div_en !== 1'b0) begin failures++; $display("FAIL rst_div_en got=%b exp=0", div_en); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_result !== 32'h0) begin failures++; $display("FAIL rst_out_result got=%h exp=0", out_result); end
    checks++; if (out_tag !== '0) begin failures++; $display("FAIL rst_out_tag got=%h exp=0", out_tag); end
    checks++; if (out_dz !== 1'b0) begin failures++; $display("FAIL rst_out_dz got=%b exp=0", out_dz); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rst_fifo_count got=%0d exp=0", fifo_count); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [31:0] r;
    clear_model();
    out_ready = 1'b1;
    in_a = 32'h40C00000;
    in_b = 32'h40000000;
    in_tag = 4'd3;
    in_valid = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
    checks++; if (div_en !== 1'b0) begin failures++; $display("FAIL single_pre_div_en got=%b exp=0", div_en); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (div_en !== 1'b1) begin failures++; $display("FAIL single_issue got=%b exp=1", div_en); end
    checks++; if (div_a !== 32'h40C00000 || div_b !== 32'h40000000) begin failures++; $display("FAIL single_div_ab got=%h/%h exp=40c00000/40000000", div_a, div_b); end
    @(negedge clk);
    r = div_result;
    checks++; if (div_en !== 1'b0) begin failures++; $display("FAIL single_one_issue got=%b exp=0", div_en); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
    checks++; if (r !== 32'h40400000) begin failures++; $display("FAIL single_div_result got=%h exp=40400000", r); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_tag !== 4'd3) begin failures++; $display("FAIL single_out_tag got=%0d exp=3", out_tag); end
    checks++; if (out_dz !== 1'b0) begin failures++; $display("FAIL single_out_dz got=%b exp=0", out_dz); end
    checks++; if (out_result !== 32'h40400000) begin failures++; $display("FAIL single_out_result got=%h exp=40400000", out_result); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", out_valid); end
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_div();
    clear_model();
    out_ready = 1'b1;
    send(32'h3F800000, 32'h00000000, 4'd5);
    send(32'h3F800000, 32'h40000000, 4'd6);
    wait_got(2, 50);
    if (got_q.size() >= 2) begin
      checks++; if (got_q[0] !== rec_t'{tag: 4'd5, dz: 1'b1, res: 32'h0}) begin failures++; $display("FAIL dz_first got=%h exp=%h", got_q[0], rec_t'{tag: 4'd5, dz: 1'b1, res: 32'h0}); end
      checks++; if (got_q[1] !== rec_t'{tag: 4'd6, dz: 1'b0, res: 32'h3F000000}) begin failures++; $display("FAIL dz_second got=%h exp=%h", got_q[1], rec_t'{tag: 4'd6, dz: 1'b0, res: 32'h3F000000}); end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_burst();
    clear_model();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(rand_fp(0), rand_fp(0), 4'(i));
    wait_got(8, 100);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 8) begin failures++; $display("FAIL burst_count got=%0d exp=8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i].tag !== 4'(i)) begin failures++; $display("FAIL burst_tag idx=%0d got=%0d exp=%0d", i, got_q[i].tag, i); end
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL burst_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      if (i > 0) begin
        checks++; if (got_cyc[i] - got_cyc[i-1] != 1) begin failures++; $display("FAIL burst_stream idx=%0d gap=%0d exp=1", i, got_cyc[i] - got_cyc[i-1]); end
      end
    end
    checks++; if (rdy_bad != 0) begin failures++; $display("FAIL burst_in_ready_rule got=%0d exp=0", rdy_bad); end
  endtask

  task automatic test_backpressure();
    logic [31:0]      h_res;
    logic [TAG_W-1:0] h_tag;
    clear_model();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(rand_fp(1), rand_fp(1), 4'(i + 8));
    repeat (4) @(posedge clk);
    @(negedge clk);
    h_res = out_result;
    h_tag = out_tag;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
    checks++; if (div_en !== 1'b0) begin failures++; $display("FAIL bp_div_en got=%b exp=0", div_en); end
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL bp_fifo_count got=%0d exp=4", fifo_count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL bp_no_delivery got=%0d exp=0", got_q.size()); end
    if (exp_q.size() > 0) begin
      checks++; if (h_tag !== exp_q[0].tag || h_res !== exp_q[0].res) begin failures++; $display("FAIL bp_head got=%0d/%h exp=%0d/%h", h_tag, h_res, exp_q[0].tag, exp_q[0].res); end
    end
    repeat (3) @(negedge clk);
    checks++; if (out_result !== h_res || out_tag !== h_tag) begin failures++; $display("FAIL bp_stable got=%0d/%h exp=%0d/%h", out_tag, out_result, h_tag, h_res); end
    checks++; if (div_en !== 1'b0) begin failures++; $display("FAIL bp_still_idle got=%b exp=0", div_en); end
    checks++; if (max_out > 2) begin failures++; $display("FAIL bp_outstanding got=%0d exp<=2", max_out); end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_got(6, 100);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 6) begin failures++; $display("FAIL bp_total got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_model();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(rand_fp(0), rand_fp(0), 4'(i + 1));
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (fifo_count !== 3'd3 || out_valid !== 1'b1) begin failures++; $display("FAIL rmid_setup got=%0d/%b exp=3/1", fifo_count, out_valid); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (div_en !== 1'b0) begin failures++; $display("FAIL rmid_div_en got=%b exp=0", div_en); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rmid_fifo_count got=%0d exp=0", fifo_count); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    out_ready = 1'b1;
    send(32'h40C00000, 32'h40000000, 4'd9);
    wait_got(1, 20);
    repeat (6) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL rmid_only_one got=%0d exp=1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== rec_t'{tag: 4'd9, dz: 1'b0, res: 32'h40400000}) begin failures++; $display("FAIL rmid_first got=%h exp=%h", got_q[0], rec_t'{tag: 4'd9, dz: 1'b0, res: 32'h40400000}); end
    end
  endtask

  task automatic test_random();
    clear_model();
    rnd_done = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(rand_fp(1), rand_fp(1), 4'($urandom));
    end
    rnd_done = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_got(200, 2000);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 200 || exp_q.size() != 200) begin failures++; $display("FAIL rnd_count got=%0d acc=%0d exp=200", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (max_out > 2) begin failures++; $display("FAIL rnd_outstanding got=%0d exp<=2", max_out); end
    checks++; if (rdy_bad != 0) begin failures++; $display("FAIL rnd_in_ready_rule got=%0d exp=0", rdy_bad); end
  endtask

  initial begin
    void'($urandom(32'd20240611));
    test_reset();
    test_single();
    test_zero_div();
    test_burst();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
